// File: rtl/tsu_q_drain_arb.sv
// Time-stamp queue drain arbiter: pops the rx/tx time-stamp queues and presents each entry on a valid/ready stream.
// Define TSU_Q_DRAIN_STATS_EN to add per-source handshake counters (rx_cnt_out, tx_cnt_out).
module tsu_q_drain_arb #(
    parameter int RD_LAT = 1,
    parameter int PRIO   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_in,
    input  logic        flush_in,
    input  logic [7:0]  rx_q_stat_in,
    input  logic [55:0] rx_q_data_in,
    output logic        rx_q_rd_en_out,
    input  logic [7:0]  tx_q_stat_in,
    input  logic [55:0] tx_q_data_in,
    output logic        tx_q_rd_en_out,
    output logic        ts_valid_out,
    input  logic        ts_ready_in,
    output logic [55:0] ts_data_out,
    output logic        ts_src_out,
`ifdef TSU_Q_DRAIN_STATS_EN
    output logic        busy_out,
    output logic [15:0] rx_cnt_out,
    output logic [15:0] tx_cnt_out
`else
    output logic        busy_out
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("tsu_q_drain_arb: RD_LAT must be in 1..4");
    end

    state_t      state, state_nxt;
    logic        sel, sel_nxt;
    logic        last_src, last_src_nxt;
    logic [1:0]  wait_cnt, wait_cnt_nxt;
    logic        ts_valid_nxt;
    logic        ts_src_nxt;
    logic [55:0] ts_data_nxt;
    logic        rx_ne, tx_ne;
    logic        grant_src;
    logic        handshake;

    assign rx_ne     = |rx_q_stat_in;
    assign tx_ne     = |tx_q_stat_in;
    assign handshake = ts_valid_out && ts_ready_in;

    // Pops are decoded from the registered state, so they are glitch-free single-cycle pulses.
    assign rx_q_rd_en_out = (state == ISSUE) && !sel;
    assign tx_q_rd_en_out = (state == ISSUE) && sel;
    assign busy_out       = (state != IDLE);

    // Source encoding: 0 = rx, 1 = tx. With only one queue waiting, that queue wins in every mode.
    always_comb begin
        grant_src = tx_ne;
        if (rx_ne && tx_ne) begin
            case (PRIO)
                1:       grant_src = 1'b0;
                2:       grant_src = 1'b1;
                default: grant_src = ~last_src;
            endcase
        end
    end

    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        last_src_nxt = last_src;
        wait_cnt_nxt = wait_cnt;
        ts_valid_nxt = ts_valid_out;
        ts_src_nxt   = ts_src_out;
        ts_data_nxt  = ts_data_out;

        case (state)
            IDLE: begin
                if (enable_in && (rx_ne || tx_ne)) begin
                    sel_nxt      = grant_src;
                    last_src_nxt = grant_src;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_nxt = WAIT_LOAD;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    ts_data_nxt  = sel ? tx_q_data_in : rx_q_data_in;
                    ts_src_nxt   = sel;
                    ts_valid_nxt = 1'b1;
                    state_nxt    = HOLD;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end
            HOLD: begin
                if (handshake) begin
                    ts_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A flush abandons the transaction; a pop already on the wire still completes at the queue.
        if (flush_in) begin
            state_nxt    = IDLE;
            ts_valid_nxt = 1'b0;
            last_src_nxt = 1'b1;
            wait_cnt_nxt = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            sel          <= 1'b0;
            last_src     <= 1'b1;
            wait_cnt     <= 2'd0;
            ts_valid_out <= 1'b0;
            ts_src_out   <= 1'b0;
            ts_data_out  <= '0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            last_src     <= last_src_nxt;
            wait_cnt     <= wait_cnt_nxt;
            ts_valid_out <= ts_valid_nxt;
            ts_src_out   <= ts_src_nxt;
            ts_data_out  <= ts_data_nxt;
        end
    end

`ifdef TSU_Q_DRAIN_STATS_EN
    // A handshake coincident with a flush still counts: the consumer has taken the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_cnt_out <= 16'd0;
            tx_cnt_out <= 16'd0;
        end else if (handshake) begin
            if (ts_src_out) tx_cnt_out <= tx_cnt_out + 16'd1;
            else            rx_cnt_out <= rx_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tsu_q_drain_arb.sv
// Bench for tsu_q_drain_arb: two instances (RD_LAT=1/round-robin, RD_LAT=3/tx priority) fed by queue models,
// checked every cycle against a transaction-level reference built from the arbitration and latency rules.
module tb_tsu_q_drain_arb;

    localparam int N = 2;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int prio_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, flush, ready;
    logic [7:0]  rx_stat [N];
    logic [7:0]  tx_stat [N];
    logic [55:0] rx_data [N];
    logic [55:0] tx_data [N];
    logic [55:0] ts_data [N];
    logic        rx_rd [N];
    logic        tx_rd [N];
    logic        ts_valid [N];
    logic        ts_src [N];
    logic        busy [N];
`ifdef TSU_Q_DRAIN_STATS_EN
    logic [15:0] rx_cnt [N];
    logic [15:0] tx_cnt [N];
`endif

    tsu_q_drain_arb #(.RD_LAT(1), .PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .enable_in(enable), .flush_in(flush),
        .rx_q_stat_in(rx_stat[0]), .rx_q_data_in(rx_data[0]), .rx_q_rd_en_out(rx_rd[0]),
        .tx_q_stat_in(tx_stat[0]), .tx_q_data_in(tx_data[0]), .tx_q_rd_en_out(tx_rd[0]),
        .ts_valid_out(ts_valid[0]), .ts_ready_in(ready), .ts_data_out(ts_data[0]),
        .ts_src_out(ts_src[0]),
`ifdef TSU_Q_DRAIN_STATS_EN
        .rx_cnt_out(rx_cnt[0]), .tx_cnt_out(tx_cnt[0]),
`endif
        .busy_out(busy[0])
    );

    tsu_q_drain_arb #(.RD_LAT(3), .PRIO(2)) u_fx (
        .clk(clk), .rst(rst), .enable_in(enable), .flush_in(flush),
        .rx_q_stat_in(rx_stat[1]), .rx_q_data_in(rx_data[1]), .rx_q_rd_en_out(rx_rd[1]),
        .tx_q_stat_in(tx_stat[1]), .tx_q_data_in(tx_data[1]), .tx_q_rd_en_out(tx_rd[1]),
        .ts_valid_out(ts_valid[1]), .ts_ready_in(ready), .ts_data_out(ts_data[1]),
        .ts_src_out(ts_src[1]),
`ifdef TSU_Q_DRAIN_STATS_EN
        .rx_cnt_out(rx_cnt[1]), .tx_cnt_out(tx_cnt[1]),
`endif
        .busy_out(busy[1])
    );

    // Queue models: circular store per instance/side plus a read-latency pipe.
    logic [55:0] mem  [N][2][256];
    int          wr_p [N][2];
    int          rd_p [N][2];
    logic [55:0] pipe [N][2][4];

    // Reference: idle flag, pending grant, expected entry, cycles until it must show.
    bit          m_idle [N];
    bit          m_last [N];
    bit          m_exp_v [N];
    bit          m_grant_due [N];
    bit          m_sel [N];
    bit          m_pend_src [N];
    logic [55:0] m_pend_data [N];
    int          m_cdn [N];
    logic [15:0] m_cnt [N][2];
    int          dut_pulses [N];

    logic [55:0] data_log0 [$];
    bit          src_log0 [$];
    bit          src_log1 [$];
    int          pulse_cyc0 [$];
    int          cyc;

    int checks = 0;
    int errors = 0;

    function automatic int fill(input int i, input int s);
        return wr_p[i][s] - rd_p[i][s];
    endfunction

    // Both waiting: fixed priority or the queue not served last; otherwise whichever is waiting.
    function automatic bit winner(input int prio, input bit rne, input bit tne, input bit last);
        if (rne && tne) begin
            if (prio == 1) return 1'b0;
            if (prio == 2) return 1'b1;
            return !last;
        end
        return tne;
    endfunction

    task automatic drive_q();
        for (int i = 0; i < N; i++) begin
            rx_stat[i] = 8'(fill(i, 0));
            tx_stat[i] = 8'(fill(i, 1));
            rx_data[i] = pipe[i][0][lat_of(i) - 1];
            tx_data[i] = pipe[i][1][lat_of(i) - 1];
        end
    endtask

    task automatic push(input int i, input int s, input logic [55:0] d);
        if (fill(i, s) < 255) begin
            mem[i][s][wr_p[i][s] % 256] = d;
            wr_p[i][s]++;
        end
        drive_q();
    endtask

    task automatic model_reset(input int i);
        m_idle[i]      = 1'b1;
        m_last[i]      = 1'b1;
        m_exp_v[i]     = 1'b0;
        m_grant_due[i] = 1'b0;
        m_sel[i]       = 1'b0;
        m_cdn[i]       = 0;
        m_cnt[i][0]    = 16'd0;
        m_cnt[i][1]    = 16'd0;
    endtask

    function automatic logic [55:0] rnd56();
        logic [63:0] g;
        g = {$urandom(), $urandom()};
        return g[55:0];
    endfunction

    // One clock: compare this cycle's outputs with the reference, advance it, then clock the queues.
    task automatic tick();
        bit          pop [N][2];
        logic [55:0] pd [N][2];
        bit          hs, nv, nidle, s;
        logic [1:0]  exp_rd;
        for (int i = 0; i < N; i++) begin
            pop[i][0] = 1'b0;
            pop[i][1] = 1'b0;
            pd[i][0]  = '0;
            pd[i][1]  = '0;
            dut_pulses[i] += int'(rx_rd[i] === 1'b1) + int'(tx_rd[i] === 1'b1);
`ifdef TSU_Q_DRAIN_STATS_EN
            checks++;
            if (rx_cnt[i] !== m_cnt[i][0] || tx_cnt[i] !== m_cnt[i][1]) begin
                errors++;
                $display("FAIL counters inst%0d: got rx=%h tx=%h, expected rx=%h tx=%h",
                         i, rx_cnt[i], tx_cnt[i], m_cnt[i][0], m_cnt[i][1]);
            end
`endif
            if (rst !== 1'b1) begin
                checks++;
                if ({rx_rd[i], tx_rd[i], ts_valid[i], ts_src[i], busy[i], ts_data[i]} !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs inst%0d: got rd=%b%b v=%b src=%b busy=%b data=%h, expected all 0",
                             i, rx_rd[i], tx_rd[i], ts_valid[i], ts_src[i], busy[i], ts_data[i]);
                end
                model_reset(i);
            end else begin
                checks++;
                if (ts_valid[i] !== m_exp_v[i]) begin
                    errors++;
                    $display("FAIL ts_valid inst%0d cyc%0d: got %b, expected %b", i, cyc, ts_valid[i], m_exp_v[i]);
                end
                if (m_exp_v[i]) begin
                    checks++;
                    if ({ts_src[i], ts_data[i]} !== {m_pend_src[i], m_pend_data[i]}) begin
                        errors++;
                        $display("FAIL entry inst%0d cyc%0d: got src=%b data=%h, expected src=%b data=%h",
                                 i, cyc, ts_src[i], ts_data[i], m_pend_src[i], m_pend_data[i]);
                    end
                end
                checks++;
                if (busy[i] !== !m_idle[i]) begin
                    errors++;
                    $display("FAIL busy inst%0d cyc%0d: got %b, expected %b", i, cyc, busy[i], !m_idle[i]);
                end
                exp_rd = m_grant_due[i] ? (m_sel[i] ? 2'b01 : 2'b10) : 2'b00;
                checks++;
                if ({rx_rd[i], tx_rd[i]} !== exp_rd) begin
                    errors++;
                    $display("FAIL rd_en inst%0d cyc%0d: got rx/tx=%b%b, expected %b",
                             i, cyc, rx_rd[i], tx_rd[i], exp_rd);
                end

                hs = m_exp_v[i] && ready;
                if (hs) begin
                    m_cnt[i][m_pend_src[i]] = m_cnt[i][m_pend_src[i]] + 16'd1;
                    if (i == 0) begin
                        src_log0.push_back(ts_src[i]);
                        data_log0.push_back(ts_data[i]);
                    end else begin
                        src_log1.push_back(ts_src[i]);
                    end
                end
                nv    = m_exp_v[i];
                nidle = m_idle[i];
                if (m_exp_v[i]) begin
                    if (hs) begin
                        nv    = 1'b0;
                        nidle = 1'b1;
                    end
                end else if (m_cdn[i] > 0) begin
                    m_cdn[i]--;
                    if (m_cdn[i] == 0) nv = 1'b1;
                end
                if (m_grant_due[i]) begin
                    s               = m_sel[i];
                    m_pend_src[i]   = s;
                    m_pend_data[i]  = mem[i][s][rd_p[i][s] % 256];
                    pd[i][s]        = m_pend_data[i];
                    pop[i][s]       = 1'b1;
                    rd_p[i][s]++;
                    m_last[i]       = s;
                    m_cdn[i]        = lat_of(i);
                    m_grant_due[i]  = 1'b0;
                    if (i == 0) pulse_cyc0.push_back(cyc);
                end
                if (m_idle[i] && enable && (fill(i, 0) > 0 || fill(i, 1) > 0) && !flush) begin
                    m_sel[i]       = winner(prio_of(i), fill(i, 0) > 0, fill(i, 1) > 0, m_last[i]);
                    m_grant_due[i] = 1'b1;
                    nidle          = 1'b0;
                end
                if (flush) begin
                    nv       = 1'b0;
                    m_cdn[i] = 0;
                    m_last[i] = 1'b1;
                    nidle    = 1'b1;
                end
                m_exp_v[i] = nv;
                m_idle[i]  = nidle;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            for (int q = 0; q < 2; q++) begin
                for (int k = 3; k > 0; k--) pipe[i][q][k] = pipe[i][q][k - 1];
                pipe[i][q][0] = pop[i][q] ? pd[i][q] : rnd56();
            end
        end
        drive_q();
    endtask

    task automatic run_until_drained(input int max_cyc, input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            done = 1'b1;
            for (int i = 0; i < N; i++)
                if (!m_idle[i] || m_grant_due[i] || (enable && (fill(i, 0) > 0 || fill(i, 1) > 0)))
                    done = 1'b0;
            if (!done) begin
                tick();
                n++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s: still busy after %0d cycles, expected drained", name, n);
        end
    endtask

    task automatic clear_logs();
        data_log0.delete();
        src_log0.delete();
        src_log1.delete();
        pulse_cyc0.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 5; k++) push(i, s, rnd56());
        enable = 1'b1;
        rst    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({rx_rd[0], tx_rd[0]} !== 2'b10) begin
            errors++;
            $display("FAIL first_grant: got rx/tx=%b%b, expected 10", rx_rd[0], tx_rd[0]);
        end
        ready = 1'b1;
        run_until_drained(2000, "reset");
    endtask

    task automatic test_single_queue();
        logic [55:0] exp_d [3];
        exp_d = '{56'h11, 56'h22, 56'h33};
        clear_logs();
        ready  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) push(i, 0, exp_d[k]);
        run_until_drained(500, "single");
        checks++;
        if (data_log0.size() != 3 || pulse_cyc0.size() != 3) begin
            errors++;
            $display("FAIL single_count: got %0d entries %0d pulses, expected 3 and 3",
                     data_log0.size(), pulse_cyc0.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (data_log0[k] !== exp_d[k] || src_log0[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_entry%0d: got src=%b data=%h, expected src=0 data=%h",
                             k, src_log0[k], data_log0[k], exp_d[k]);
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (pulse_cyc0[k] - pulse_cyc0[k - 1] != 4) begin
                    errors++;
                    $display("FAIL pulse_spacing%0d: got %0d cycles, expected 4",
                             k, pulse_cyc0[k] - pulse_cyc0[k - 1]);
                end
            end
        end
    endtask

    task automatic test_order();
        bit exp0 [4];
        bit exp1 [4];
        exp0 = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp1 = '{1'b1, 1'b1, 1'b0, 1'b0};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_logs();
        for (int i = 0; i < N; i++)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 2; k++) push(i, s, rnd56());
        run_until_drained(500, "order");
        checks++;
        if (src_log0.size() != 4 || src_log1.size() != 4) begin
            errors++;
            $display("FAIL order_count: got %0d and %0d entries, expected 4 and 4", src_log0.size(), src_log1.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (src_log0[k] !== exp0[k] || src_log1[k] !== exp1[k]) begin
                    errors++;
                    $display("FAIL order%0d: got rr=%b fx=%b, expected rr=%b fx=%b",
                             k, src_log0[k], src_log1[k], exp0[k], exp1[k]);
                end
            end
        end
        checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL order_idle: got busy=%b%b, expected 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            push(i, 0, 56'hABCDEF);
            push(i, 1, rnd56());
        end
        n = 0;
        while (ts_valid[1] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (ts_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_wait: ts_valid never rose within 40 cycles, expected 1");
        end
        repeat (10) begin
            tick();
            checks++;
            if (ts_valid[0] !== 1'b1 || ts_data[0] !== 56'hABCDEF || ts_src[0] !== 1'b0 ||
                rx_rd[0] !== 1'b0 || tx_rd[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got v=%b data=%h src=%b rd=%b%b, expected v=1 data=abcdef src=0 rd=00",
                         ts_valid[0], ts_data[0], ts_src[0], rx_rd[0], tx_rd[0]);
            end
        end
        ready = 1'b1;
        tick();
        checks++;
        if (ts_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got v=%b busy=%b, expected 0 0", ts_valid[0], busy[0]);
        end
        run_until_drained(500, "bp");
    endtask

    task automatic test_flush();
        int n, base;
        bit seen_v;
        ready = 1'b1;
        for (int i = 0; i < N; i++) push(i, 0, rnd56());
        base = dut_pulses[1];
        n    = 0;
        while (rx_rd[1] !== 1'b1 && tx_rd[1] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b, expected 0", busy[1]);
        end
        seen_v = 1'b0;
        repeat (8) begin
            if (ts_valid[1] !== 1'b0) seen_v = 1'b1;
            tick();
        end
        checks++;
        if (seen_v || dut_pulses[1] - base != 1) begin
            errors++;
            $display("FAIL flush_discard: got valid_seen=%b pulses=%0d, expected 0 and 1",
                     seen_v, dut_pulses[1] - base);
        end

        ready = 1'b0;
        for (int i = 0; i < N; i++) push(i, 0, rnd56());
        n = 0;
        while (ts_valid[1] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ts_valid[0] !== 1'b0 || ts_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_handshake: got valid=%b%b, expected 00", ts_valid[0], ts_valid[1]);
        end
        run_until_drained(200, "flush");
    endtask

    task automatic test_full_stat();
        enable = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 255; k++) push(i, 0, rnd56());
        tick();
        enable = 1'b1;
        tick();
        checks++;
        if (rx_rd[0] !== 1'b1 || rx_rd[1] !== 1'b1) begin
            errors++;
            $display("FAIL stat_ff_grant: got rx_rd=%b%b, expected 11", rx_rd[0], rx_rd[1]);
        end
        run_until_drained(4000, "full");
    endtask

    task automatic test_random();
        repeat (1500) begin
            enable = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++)
                for (int s = 0; s < 2; s++)
                    if ($urandom_range(0, 15) == 0 && fill(i, s) < 200) push(i, s, rnd56());
            tick();
        end
        flush  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        run_until_drained(4000, "random");
    endtask

`ifdef TSU_Q_DRAIN_STATS_EN
    task automatic test_stats();
        logic [15:0] tx_before, rx_before;
        int n;
        enable = 1'b0;
        force u_rr.rx_cnt_out = 16'hFFFE;
        #1;
        release u_rr.rx_cnt_out;
        m_cnt[0][0] = 16'hFFFE;
        tx_before   = m_cnt[0][1];
        enable = 1'b1;
        ready  = 1'b1;
        push(0, 0, rnd56());
        push(0, 0, rnd56());
        run_until_drained(200, "stats");
        checks++;
        if (rx_cnt[0] !== 16'h0000 || tx_cnt[0] !== tx_before) begin
            errors++;
            $display("FAIL stats_wrap: got rx=%h tx=%h, expected rx=0000 tx=%h", rx_cnt[0], tx_cnt[0], tx_before);
        end
        ready = 1'b0;
        push(0, 0, rnd56());
        n = 0;
        while (ts_valid[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        rx_before = rx_cnt[0];
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (rx_cnt[0] !== 16'h0000 || tx_cnt[0] !== tx_before) begin
            errors++;
            $display("FAIL stats_flush: got rx=%h tx=%h (rx before %h), expected rx=0000 tx=%h",
                     rx_cnt[0], tx_cnt[0], rx_before, tx_before);
        end
        ready = 1'b1;
        run_until_drained(200, "stats2");
    endtask
`endif

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        flush  = 1'b0;
        ready  = 1'b0;
        cyc    = 0;
        for (int i = 0; i < N; i++) begin
            model_reset(i);
            dut_pulses[i] = 0;
            for (int s = 0; s < 2; s++) begin
                wr_p[i][s] = 0;
                rd_p[i][s] = 0;
                for (int k = 0; k < 4; k++) pipe[i][s][k] = '0;
            end
        end
        drive_q();
        @(posedge clk);
        #1;
        test_reset();
        test_single_queue();
        test_order();
        test_backpressure();
        test_flush();
        test_full_stat();
        test_random();
`ifdef TSU_Q_DRAIN_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
